// File: rtl/bpu_btb.sv
// -----------------------------------------------------------------------------
// bpu_btb
//
// Fetch-stage branch prediction unit. It is a direct-mapped branch target
// buffer, and each entry holds a saturating taken counter.
//
// Fetch looks up the current PC in the same cycle and gets a hit, a taken
// prediction and the next PC. The execute stage writes back at most one
// resolved control transfer per cycle. A flush request clears the table one
// entry per cycle, from index 0 up to ENTRIES-1.
//
// Optional feature, controlled by the macro BPU_STATS_EN:
//   - When the macro is defined, the block has two saturating 32-bit counters
//     and their ports, stat_lookups_o and stat_hits_o.
//   - When the macro is undefined, those counters and ports do not exist.
//
// Parameters:
//   XLEN     address width
//   ENTRIES  table depth; must be a power of two and at least 2
//   CNT_W    width of the saturating counter; at least 1
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   pred_valid_i     fetch lookup request
//   pred_pc_i        fetch PC
//   pred_hit_o       the lookup hit a valid entry with a matching tag
//   pred_taken_o     the branch is predicted taken
//   pred_target_o    predicted next PC (the stored target, or pc+4)
//   upd_valid_i      a resolved control transfer is present
//   upd_pc_i         PC of the resolved instruction
//   upd_taken_i      actual outcome
//   upd_target_i     actual target
//   upd_is_jump_i    the instruction is JAL or JALR
//   flush_i          request to invalidate the whole table
//   busy_o           a flush sweep is in progress
//   stat_lookups_o   (BPU_STATS_EN) number of lookups accepted in IDLE
//   stat_hits_o      (BPU_STATS_EN) number of lookup hits
//
// Handshake: there is no backpressure.
//   - A lookup is evaluated in every cycle in which pred_valid_i=1.
//   - An update is consumed in every cycle in which upd_valid_i=1 and the
//     block is idle.
//   - While busy_o=1, updates and new flush requests are silently dropped.
// -----------------------------------------------------------------------------
module bpu_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pred_valid_i,
    input  logic [XLEN-1:0] pred_pc_i,
    output logic            pred_hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_is_jump_i,
    input  logic            flush_i,
`ifdef BPU_STATS_EN
    output logic [31:0]     stat_lookups_o,
    output logic [31:0]     stat_hits_o,
`endif
    output logic            busy_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;

    // Table storage
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic             jump_q   [ENTRIES];

    // The low two bits of the update PC play no part in the index or tag
    logic unused_upd_pc_lsbs;
    assign unused_upd_pc_lsbs = ^upd_pc_i[1:0];

    // -------------------------------------------------------------------------
    // Lookup: purely combinational from the registered table. A write made in
    // the same cycle is not seen until the next cycle.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] pred_idx;
    logic [TAG_W-1:0] pred_tag;
    logic             pred_hit;
    logic             pred_taken;

    assign pred_idx = pred_pc_i[IDX_W+1:2];
    assign pred_tag = pred_pc_i[XLEN-1:IDX_W+2];

    always_comb begin
        pred_hit   = pred_valid_i && (state_q == ST_IDLE) &&
                     valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
        pred_taken = pred_hit && (jump_q[pred_idx] || cnt_q[pred_idx][CNT_W-1]);
    end

    assign pred_hit_o    = pred_hit;
    assign pred_taken_o  = pred_taken;
    assign pred_target_o = pred_taken ? target_q[pred_idx]
                                      : pred_pc_i + XLEN'(4);

    // -------------------------------------------------------------------------
    // Update: work out the single-entry write that the execute stage requests
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             wr_en;
    logic [TAG_W-1:0] wr_tag;
    logic [XLEN-1:0]  wr_target;
    logic [CNT_W-1:0] wr_cnt;
    logic             wr_jump;

    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[XLEN-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        wr_en     = 1'b0;
        wr_tag    = tag_q[upd_idx];
        wr_target = target_q[upd_idx];
        wr_cnt    = cnt_q[upd_idx];
        wr_jump   = jump_q[upd_idx];
        // If a flush arrives in the same cycle as an update, the flush wins
        // and the update is dropped
        if ((state_q == ST_IDLE) && upd_valid_i && !flush_i) begin
            if (upd_hit && upd_taken_i) begin
                wr_en     = 1'b1;
                wr_target = upd_target_i;
                wr_jump   = upd_is_jump_i;
                if (cnt_q[upd_idx] != CNT_MAX) begin
                    wr_cnt = cnt_q[upd_idx] + CNT_W'(1);
                end
            end else if (upd_hit) begin
                wr_en = 1'b1;
                if (cnt_q[upd_idx] != '0) begin
                    wr_cnt = cnt_q[upd_idx] - CNT_W'(1);
                end
            end else if (upd_taken_i) begin
                // Allocate, or replace the aliasing entry. A new jump starts
                // fully saturated; a new branch starts weakly taken
                wr_en     = 1'b1;
                wr_tag    = upd_tag;
                wr_target = upd_target_i;
                wr_jump   = upd_is_jump_i;
                wr_cnt    = upd_is_jump_i ? CNT_MAX : CNT_WEAK;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Flush sequencer
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                    sweep_d = '0;
                end
            end
            ST_FLUSH: begin
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    assign busy_o = (state_q == ST_FLUSH);

    // -------------------------------------------------------------------------
    // Table write port. The flush sweep and updates never write in the same
    // cycle, because updates are only accepted in IDLE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
                jump_q[i]   <= 1'b0;
            end
        end else if (state_q == ST_FLUSH) begin
            valid_q[sweep_q] <= 1'b0;
            cnt_q[sweep_q]   <= '0;
            jump_q[sweep_q]  <= 1'b0;
        end else if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= wr_tag;
            target_q[upd_idx] <= wr_target;
            cnt_q[upd_idx]    <= wr_cnt;
            jump_q[upd_idx]   <= wr_jump;
        end
    end

`ifdef BPU_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics counters. They saturate, and only reset clears them; a flush
    // leaves them unchanged.
    // -------------------------------------------------------------------------
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_hits_q, stat_hits_d;

    always_comb begin
        stat_lookups_d = stat_lookups_q;
        stat_hits_d    = stat_hits_q;
        if (pred_valid_i && (state_q == ST_IDLE) && (stat_lookups_q != 32'hFFFF_FFFF)) begin
            stat_lookups_d = stat_lookups_q + 32'd1;
        end
        if (pred_hit && (stat_hits_q != 32'hFFFF_FFFF)) begin
            stat_hits_d = stat_hits_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups_q <= '0;
            stat_hits_q    <= '0;
        end else begin
            stat_lookups_q <= stat_lookups_d;
            stat_hits_q    <= stat_hits_d;
        end
    end

    assign stat_lookups_o = stat_lookups_q;
    assign stat_hits_o    = stat_hits_q;
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// -----------------------------------------------------------------------------
// tb_bpu_btb
//
// Self-checking bench for bpu_btb, configured with ENTRIES=16 and CNT_W=2.
//
// The bench keeps a behavioural table model, written with plain integer
// arithmetic:
//   - index = (pc/4) mod ENTRIES
//   - tag   = pc / (4*ENTRIES)
// The model predicts every lookup.
//
// Timing of each cycle:
//   - Inputs are driven just after the rising edge.
//   - Outputs are sampled on the falling edge.
//   - The model is advanced after sampling, so a lookup always sees the
//     contents from before the update.
// -----------------------------------------------------------------------------
module tb_bpu_btb;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 2;
    localparam int CMAX    = 2**CNT_W - 1;
    localparam int CWEAK   = 2**(CNT_W - 1);

    logic            clk;
    logic            rst_n;
    logic            pred_valid_i;
    logic [XLEN-1:0] pred_pc_i;
    logic            pred_hit_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_is_jump_i;
    logic            flush_i;
    logic            busy_o;
`ifdef BPU_STATS_EN
    logic [31:0]     stat_lookups_o;
    logic [31:0]     stat_hits_o;
`endif

    bpu_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_valid_i  (pred_valid_i),
        .pred_pc_i     (pred_pc_i),
        .pred_hit_o    (pred_hit_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .upd_is_jump_i (upd_is_jump_i),
        .flush_i       (flush_i),
`ifdef BPU_STATS_EN
        .stat_lookups_o(stat_lookups_o),
        .stat_hits_o   (stat_hits_o),
`endif
        .busy_o        (busy_o)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference model
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    bit          m_jump   [ENTRIES];
    int          m_busy;
    int          m_lookups;
    int          m_hits;

    // Values observed in the most recent cycle
    logic        o_hit, o_taken, o_busy;
    logic [31:0] o_target;

    function automatic int m_idx(logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tg(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic m_clear_table();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 0;
            m_jump[i]  = 1'b0;
        end
    endtask

    task automatic m_apply(logic [31:0] pc, bit taken, logic [31:0] tgt, bit jump);
        int  i;
        bit  hit;
        i   = m_idx(pc);
        hit = m_valid[i] && (m_tag[i] == m_tg(pc));
        if (hit && taken) begin
            m_cnt[i]    = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
            m_target[i] = tgt;
            m_jump[i]   = jump;
        end else if (hit) begin
            m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end else if (taken) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = m_tg(pc);
            m_target[i] = tgt;
            m_jump[i]   = jump;
            m_cnt[i]    = jump ? CMAX : CWEAK;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one full clock cycle: drive the inputs, check against the model,
    // then advance the model
    task automatic cyc(bit pv, logic [31:0] ppc, bit uv, logic [31:0] upc,
                       bit ut, logic [31:0] utgt, bit uj, bit fl);
        int          i;
        bit          e_hit, e_taken;
        logic [31:0] e_target;
        pred_valid_i  = pv;
        pred_pc_i     = ppc;
        upd_valid_i   = uv;
        upd_pc_i      = upc;
        upd_taken_i   = ut;
        upd_target_i  = utgt;
        upd_is_jump_i = uj;
        flush_i       = fl;
        @(negedge clk);
        i        = m_idx(ppc);
        e_hit    = pv && (m_busy == 0) && m_valid[i] && (m_tag[i] == m_tg(ppc));
        e_taken  = e_hit && (m_jump[i] || (m_cnt[i] >= CWEAK));
        e_target = e_taken ? m_target[i] : ppc + 32'd4;
        o_hit    = pred_hit_o;
        o_taken  = pred_taken_o;
        o_target = pred_target_o;
        o_busy   = busy_o;
        chk("hit", {31'd0, o_hit}, {31'd0, e_hit});
        chk("taken", {31'd0, o_taken}, {31'd0, e_taken});
        chk("target", o_target, e_target);
        chk("busy", {31'd0, o_busy}, (m_busy > 0) ? 32'd1 : 32'd0);
`ifdef BPU_STATS_EN
        chk("stat_lookups", stat_lookups_o, m_lookups);
        chk("stat_hits", stat_hits_o, m_hits);
`endif
        if (pv && (m_busy == 0)) m_lookups++;
        if (e_hit) m_hits++;
        if (m_busy > 0) begin
            m_busy--;
        end else if (fl) begin
            m_busy = ENTRIES;
            m_clear_table();
        end else if (uv) begin
            m_apply(upc, ut, utgt, uj);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lk(logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic up(logic [31:0] pc, bit taken, logic [31:0] tgt, bit jump);
        cyc(1'b0, 32'd0, 1'b1, pc, taken, tgt, jump, 1'b0);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        pred_valid_i  = 1'b1;
        pred_pc_i     = 32'h100;
        upd_valid_i   = 1'b0;
        upd_pc_i      = '0;
        upd_taken_i   = 1'b0;
        upd_target_i  = '0;
        upd_is_jump_i = 1'b0;
        flush_i       = 1'b0;
        #1;
        chk("rst_hit", {31'd0, pred_hit_o}, 32'd0);
        chk("rst_taken", {31'd0, pred_taken_o}, 32'd0);
        chk("rst_target", pred_target_o, 32'h104);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_clear_table();
        m_busy    = 0;
        m_lookups = 0;
        m_hits    = 0;
    endtask

    logic [31:0] fill_pc [4];

    initial begin
        fill_pc[0] = 32'h104;
        fill_pc[1] = 32'h108;
        fill_pc[2] = 32'h10c;
        fill_pc[3] = 32'h110;
        rst_n = 1'b0;
        #2;
        do_reset();

        // 1. Lookup immediately after reset
        lk(32'h100);
        chk("p1_hit", {31'd0, o_hit}, 32'd0);
        chk("p1_target", o_target, 32'h104);

        // 2. Train the counter at 0x100
        up(32'h100, 1'b1, 32'h80, 1'b0);
        lk(32'h100);
        chk("p2_hit", {31'd0, o_hit}, 32'd1);
        chk("p2_taken", {31'd0, o_taken}, 32'd1);
        chk("p2_target", o_target, 32'h80);
        up(32'h100, 1'b1, 32'h80, 1'b0);
        up(32'h100, 1'b1, 32'h80, 1'b0);
        up(32'h100, 1'b0, 32'h0, 1'b0);
        lk(32'h100);
        chk("p2_sat_taken", {31'd0, o_taken}, 32'd1);
        up(32'h100, 1'b0, 32'h0, 1'b0);
        up(32'h100, 1'b0, 32'h0, 1'b0);
        lk(32'h100);
        chk("p2_nt_hit", {31'd0, o_hit}, 32'd1);
        chk("p2_nt_taken", {31'd0, o_taken}, 32'd0);
        chk("p2_nt_target", o_target, 32'h104);

        // 3. Aliasing at index 0
        lk(32'h140);
        chk("p3_alias_miss", {31'd0, o_hit}, 32'd0);
        up(32'h140, 1'b1, 32'h300, 1'b0);
        lk(32'h100);
        chk("p3_replaced", {31'd0, o_hit}, 32'd0);
        lk(32'h140);
        chk("p3_new_target", o_target, 32'h300);

        // 4. Jump entry, then a lookup and an update in the same cycle
        up(32'h200, 1'b1, 32'h400, 1'b1);
        lk(32'h200);
        chk("p4_jal_taken", {31'd0, o_taken}, 32'd1);
        chk("p4_jal_target", o_target, 32'h400);
        cyc(1'b1, 32'h240, 1'b1, 32'h240, 1'b1, 32'h500, 1'b0, 1'b0);
        chk("p4_same_cycle_miss", {31'd0, o_hit}, 32'd0);
        lk(32'h240);
        chk("p4_next_cycle_hit", {31'd0, o_hit}, 32'd1);
        lk(32'hFFFF_FFFC);
        chk("wrap_target", o_target, 32'h0);

        // 5a. Flush sweep; an update at flush cycle 3 is dropped
        for (int k = 0; k < 4; k++) up(fill_pc[k], 1'b1, 32'h700 + 32'(k) * 4, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        for (int k = 1; k <= ENTRIES; k++) begin
            if (k == 3) cyc(1'b1, fill_pc[0], 1'b1, 32'h120, 1'b1, 32'h600, 1'b0, 1'b0);
            else if (k == 5) cyc(1'b1, fill_pc[1], 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
            else lk(fill_pc[k % 4]);
            chk("flush_busy", {31'd0, o_busy}, 32'd1);
            chk("flush_miss", {31'd0, o_hit}, 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            lk(fill_pc[k]);
            chk("post_flush_miss", {31'd0, o_hit}, 32'd0);
        end
        chk("post_flush_idle", {31'd0, o_busy}, 32'd0);
        lk(32'h120);
        chk("dropped_update", {31'd0, o_hit}, 32'd0);

        // 5b. Reset asserted at flush cycle 5
        for (int k = 0; k < 4; k++) up(fill_pc[k], 1'b1, 32'h800, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) lk(fill_pc[0]);
        rst_n        = 1'b0;
        pred_valid_i = 1'b1;
        pred_pc_i    = fill_pc[2];
        #1;
        chk("midflush_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("midflush_rst_hit", {31'd0, pred_hit_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_clear_table();
        m_busy    = 0;
        m_lookups = 0;
        m_hits    = 0;
        for (int k = 0; k < 4; k++) begin
            lk(fill_pc[k]);
            chk("post_rst_miss", {31'd0, o_hit}, 32'd0);
        end

`ifdef BPU_STATS_EN
        // 6. Statistics: 10 lookups, 4 of which hit; a flush leaves them unchanged
        do_reset();
        up(32'h180, 1'b1, 32'h500, 1'b0);
        for (int k = 0; k < 10; k++) lk((k < 4) ? 32'h180 : 32'h184);
        chk("stat_lookups_10", stat_lookups_o, 32'd10);
        chk("stat_hits_4", stat_hits_o, 32'd4);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < ENTRIES + 1; k++) cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("stat_lookups_flush", stat_lookups_o, 32'd10);
        chk("stat_hits_flush", stat_hits_o, 32'd4);
`endif

        // 7. Random traffic over a few tags per index, with occasional flushes
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ppc, upc, tgt;
            ppc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            tgt = $urandom & 32'hFFFF_FFFC;
            cyc(1'($urandom_range(0, 3) != 0), ppc,
                1'($urandom_range(0, 1)), upc,
                1'($urandom_range(0, 2) != 0), tgt,
                1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
